// File: rtl/crc_pause_stack_ctrl_if.sv
// Request/response bundle between the fingerprint register slave, the CRC datapath and
// crc_pause_stack_ctrl. max_depth exists only when CRC_PAUSE_WATERMARK_EN is defined.
interface crc_pause_stack_ctrl_if #(
  parameter int KEY_WIDTH   = 4,
  parameter int STACK_DEPTH = 8
);
  localparam int PTR_W = $clog2(STACK_DEPTH) + 1;

  logic                    pause_req;
  logic                    unpause_req;
  logic                    fprint_enable;
  logic [KEY_WIDTH-1:0]    cur_task;
  logic [2**KEY_WIDTH-1:0] pause_mask;
  logic                    err_clr;
  logic                    pause_store;
  logic                    pause_reset;
  logic                    unpause_load;
  logic                    unpause_setfsm;
  logic [KEY_WIDTH-1:0]    restore_task;
  logic                    waitrequest;
  logic [PTR_W-1:0]        depth;
  logic                    overflow_err;
  logic                    underflow_err;
`ifdef CRC_PAUSE_WATERMARK_EN
  logic [PTR_W-1:0]        max_depth;
`endif

  modport master (
`ifdef CRC_PAUSE_WATERMARK_EN
    input  max_depth,
`endif
    output pause_req, unpause_req, fprint_enable, cur_task, pause_mask, err_clr,
    input  pause_store, pause_reset, unpause_load, unpause_setfsm, restore_task,
    input  waitrequest, depth, overflow_err, underflow_err
  );

  modport slave (
`ifdef CRC_PAUSE_WATERMARK_EN
    output max_depth,
`endif
    input  pause_req, unpause_req, fprint_enable, cur_task, pause_mask, err_clr,
    output pause_store, pause_reset, unpause_load, unpause_setfsm, restore_task,
    output waitrequest, depth, overflow_err, underflow_err
  );
endinterface

// File: rtl/crc_pause_stack_ctrl.sv
// Nested pause/unpause sequencer for the fingerprint CRC unit with a LIFO of task keys.
// Optional macro CRC_PAUSE_WATERMARK_EN adds the max_depth high-water mark output.
module crc_pause_stack_ctrl #(
  parameter int KEY_WIDTH   = 4,
  parameter int STACK_DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  crc_pause_stack_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_STORE  = 3'd1,
    P_RESET  = 3'd2,
    P_REL    = 3'd3,
    U_LOAD   = 3'd4,
    U_SETFSM = 3'd5,
    U_REL    = 3'd6
  } state_t;

  state_t               state_reg;
  logic [PTR_W-1:0]     depth_reg;
  logic [PTR_W-1:0]     depth_next;
  logic [PTR_W-1:0]     top_ptr;
  logic [KEY_WIDTH-1:0] stack_mem [0:STACK_DEPTH-1];
  logic                 pause_store_reg, pause_reset_reg, unpause_load_reg, unpause_setfsm_reg;
  logic                 waitrequest_reg, overflow_reg, underflow_reg;
  logic                 stack_full, stack_empty;
  logic                 pause_seen, unpause_seen, push, pop_start, ovf_set, unf_set;

  assign stack_full  = (depth_reg == PTR_W'(STACK_DEPTH));
  assign stack_empty = (depth_reg == '0);
  assign top_ptr     = depth_reg - PTR_W'(1);

  assign bus.restore_task = stack_empty ? '0 : stack_mem[top_ptr[IDX_W-1:0]];

  // pause_req has priority in IDLE: a concurrent unpause is dropped without an error.
  assign pause_seen   = (state_reg == IDLE) && bus.pause_req;
  assign unpause_seen = (state_reg == IDLE) && !bus.pause_req && bus.unpause_req;
  assign push         = pause_seen && bus.fprint_enable && !stack_full;
  assign ovf_set      = pause_seen && bus.fprint_enable && stack_full;
  assign pop_start    = unpause_seen && !stack_empty && !bus.pause_mask[bus.restore_task];
  assign unf_set      = unpause_seen && stack_empty;

  always_comb begin
    depth_next = depth_reg;
    if (push)
      depth_next = depth_reg + PTR_W'(1);
    else if (state_reg == U_SETFSM)
      depth_next = depth_reg - PTR_W'(1);
  end

  // Stack contents need no reset: entries above depth are never observed.
  always_ff @(posedge clk) begin
    if (push)
      stack_mem[depth_reg[IDX_W-1:0]] <= bus.cur_task;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      depth_reg          <= '0;
      pause_store_reg    <= 1'b0;
      pause_reset_reg    <= 1'b0;
      unpause_load_reg   <= 1'b0;
      unpause_setfsm_reg <= 1'b0;
      waitrequest_reg    <= 1'b0;
      overflow_reg       <= 1'b0;
      underflow_reg      <= 1'b0;
    end else begin
      depth_reg          <= depth_next;
      pause_store_reg    <= 1'b0;
      pause_reset_reg    <= 1'b0;
      unpause_load_reg   <= 1'b0;
      unpause_setfsm_reg <= 1'b0;
      waitrequest_reg    <= 1'b0;
      overflow_reg       <= ovf_set | (overflow_reg & ~bus.err_clr);
      underflow_reg      <= unf_set | (underflow_reg & ~bus.err_clr);
      case (state_reg)
        IDLE: begin
          if (push) begin
            state_reg       <= P_STORE;
            pause_store_reg <= 1'b1;
            waitrequest_reg <= 1'b1;
          end else if (pop_start) begin
            state_reg        <= U_LOAD;
            unpause_load_reg <= 1'b1;
            waitrequest_reg  <= 1'b1;
          end
        end
        P_STORE: begin
          state_reg       <= P_RESET;
          pause_reset_reg <= 1'b1;
          waitrequest_reg <= 1'b1;
        end
        P_RESET: begin
          state_reg       <= P_REL;
          waitrequest_reg <= 1'b1;
        end
        U_LOAD: begin
          state_reg          <= U_SETFSM;
          unpause_setfsm_reg <= 1'b1;
          waitrequest_reg    <= 1'b1;
        end
        U_SETFSM: begin
          state_reg       <= U_REL;
          waitrequest_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pause_store    = pause_store_reg;
  assign bus.pause_reset    = pause_reset_reg;
  assign bus.unpause_load   = unpause_load_reg;
  assign bus.unpause_setfsm = unpause_setfsm_reg;
  assign bus.waitrequest    = waitrequest_reg;
  assign bus.depth          = depth_reg;
  assign bus.overflow_err   = overflow_reg;
  assign bus.underflow_err  = underflow_reg;

`ifdef CRC_PAUSE_WATERMARK_EN
  logic [PTR_W-1:0] max_depth_reg;

  // err_clr restarts the mark from the occupancy being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      max_depth_reg <= '0;
    else if (bus.err_clr)
      max_depth_reg <= depth_next;
    else if (push && (depth_next > max_depth_reg))
      max_depth_reg <= depth_next;
  end

  assign bus.max_depth = max_depth_reg;
`endif
endmodule

// File: tb/tb_crc_pause_stack_ctrl.sv
// Randomised and directed bench for crc_pause_stack_ctrl against a queue-based task-level model.
module tb_crc_pause_stack_ctrl;
  localparam int KW = 4;
  localparam int SD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_pause_stack_ctrl_if #(.KEY_WIDTH(KW), .STACK_DEPTH(SD)) bus_if ();
  crc_pause_stack_ctrl #(.KEY_WIDTH(KW), .STACK_DEPTH(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: the paused keys as a queue (back = top) plus the two sticky flags.
  logic [3:0]  stk [$];
  logic        ovf_m = 1'b0;
  logic        unf_m = 1'b0;
  // Per-cycle view {ps,pr,ul,us,wr,depth[3:0],restore_task[3:0]} for 4 cycles after a request.
  logic [12:0] obs   [1:4];
  logic [12:0] exp_v [1:4];
  logic [1:0]  obs_fl;

  function automatic logic [12:0] sample();
    return {bus_if.pause_store, bus_if.pause_reset, bus_if.unpause_load, bus_if.unpause_setfsm,
            bus_if.waitrequest, bus_if.depth, bus_if.restore_task};
  endfunction

  function automatic logic [12:0] pk(logic [4:0] f, int d, logic [3:0] t);
    return {f, 4'(d), t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request cycle then three quiet (or noisy) cycles, updating the model.
  // noise: 0 none, 1 both strobes held high while busy, 2 random strobes while busy.
  task automatic apply(input logic p, input logic u, input logic en, input logic [3:0] key,
                       input logic [15:0] mask, input logic clr, input int noise);
    int         n;
    logic [3:0] top, newtop;
    logic       act, oset, uset;
    n    = stk.size();
    top  = (n != 0) ? stk[n-1] : 4'd0;
    act  = 1'b0;
    oset = 1'b0;
    uset = 1'b0;
    for (int c = 1; c <= 4; c++) exp_v[c] = pk(5'b0, n, top);
    if (p) begin
      if (en && n < SD) begin
        stk.push_back(key);
        exp_v[1] = pk(5'b10001, n + 1, key);
        exp_v[2] = pk(5'b01001, n + 1, key);
        exp_v[3] = pk(5'b00001, n + 1, key);
        exp_v[4] = pk(5'b00000, n + 1, key);
        act = 1'b1;
      end else if (en) begin
        oset = 1'b1;
      end
    end else if (u) begin
      if (n == 0) begin
        uset = 1'b1;
      end else if (!mask[top]) begin
        void'(stk.pop_back());
        newtop = (n > 1) ? stk[n-2] : 4'd0;
        exp_v[1] = pk(5'b00101, n, top);
        exp_v[2] = pk(5'b00011, n, top);
        exp_v[3] = pk(5'b00001, n - 1, newtop);
        exp_v[4] = pk(5'b00000, n - 1, newtop);
        act = 1'b1;
      end
    end
    ovf_m = oset | (ovf_m & ~clr);
    unf_m = uset | (unf_m & ~clr);

    bus_if.pause_req     = p;
    bus_if.unpause_req   = u;
    bus_if.fprint_enable = en;
    bus_if.cur_task      = key;
    bus_if.pause_mask    = mask;
    bus_if.err_clr       = clr;
    step();
    obs[1] = sample();
    obs_fl = {bus_if.overflow_err, bus_if.underflow_err};
    bus_if.pause_req   = 1'b0;
    bus_if.unpause_req = 1'b0;
    bus_if.err_clr     = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      if (act && noise == 1) begin
        bus_if.pause_req   = 1'b1;
        bus_if.unpause_req = 1'b1;
      end else if (act && noise == 2) begin
        bus_if.pause_req   = 1'($urandom);
        bus_if.unpause_req = 1'($urandom);
      end
      step();
      obs[c] = sample();
    end
    bus_if.pause_req   = 1'b0;
    bus_if.unpause_req = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.pause_req = 1'b0; bus_if.unpause_req = 1'b0; bus_if.fprint_enable = 1'b0;
    bus_if.cur_task = '0; bus_if.pause_mask = '0; bus_if.err_clr = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    vectors++;
    if ({sample(), bus_if.overflow_err, bus_if.underflow_err} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %b want all zero", {sample(), bus_if.overflow_err, bus_if.underflow_err});
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({sample(), bus_if.overflow_err, bus_if.underflow_err} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %b want all zero", {sample(), bus_if.overflow_err, bus_if.underflow_err});
    end
  endtask

  task automatic test_single_pause();
    logic [12:0] want [1:4];
    want = '{13'b10001_0001_0011, 13'b01001_0001_0011, 13'b00001_0001_0011, 13'b00000_0001_0011};
    apply(1'b1, 1'b0, 1'b1, 4'd3, 16'h0, 1'b0, 0);
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (obs[c] !== want[c]) begin
        miscompares++;
        $display("FAIL single_pause c%0d: got %b want %b", c, obs[c], want[c]);
      end
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
    vectors++;
    if (obs[4] !== 13'd0) begin
      miscompares++;
      $display("FAIL single_unpause: got %b want %b", obs[4], 13'd0);
    end
  endtask

  task automatic test_nested();
    logic [3:0] keys [0:2];
    logic [3:0] rev  [0:2];
    keys = '{4'd1, 4'd2, 4'd5};
    rev  = '{4'd5, 4'd2, 4'd1};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b1, keys[i], 16'h0, 1'b0, 0);
      vectors++;
      if (obs[4] !== pk(5'b0, i + 1, keys[i])) begin
        miscompares++;
        $display("FAIL nested_push%0d: got %b want %b", i, obs[4], pk(5'b0, i + 1, keys[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
      vectors++;
      if (obs[1] !== pk(5'b00101, 3 - i, rev[i])) begin
        miscompares++;
        $display("FAIL nested_load%0d: got %b want %b", i, obs[1], pk(5'b00101, 3 - i, rev[i]));
      end
      vectors++;
      if ({obs[2][9], obs[2][7:4], obs[3][7:4]} !== {1'b1, 4'(3 - i), 4'(2 - i)}) begin
        miscompares++;
        $display("FAIL nested_pop%0d: got us=%b depth %0d->%0d want 1 %0d->%0d",
                 i, obs[2][9], obs[2][7:4], obs[3][7:4], 3 - i, 2 - i);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= SD; i++) apply(1'b1, 1'b0, 1'b1, 4'(i), 16'h0, 1'b0, 0);
    vectors++;
    if (obs[1] !== pk(5'b0, SD, 4'd7) || obs_fl !== 2'b10) begin
      miscompares++;
      $display("FAIL overflow: got %b flags %b want %b flags 10", obs[1], obs_fl, pk(5'b0, SD, 4'd7));
    end
    apply(1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 1'b1, 0);
    vectors++;
    if (obs_fl !== 2'b00) begin
      miscompares++;
      $display("FAIL overflow_clear: got flags %b want 00", obs_fl);
    end
    for (int i = 0; i < SD; i++) apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
    vectors++;
    if (obs[1] !== 13'd0 || obs_fl !== 2'b01) begin
      miscompares++;
      $display("FAIL underflow: got %b flags %b want %b flags 01", obs[1], obs_fl, 13'd0);
    end
    apply(1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 1'b1, 0);
  endtask

  task automatic test_mask();
    apply(1'b1, 1'b0, 1'b1, 4'd4, 16'h0, 1'b0, 0);
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0010, 1'b0, 0);
    vectors++;
    if (obs[1] !== pk(5'b0, 1, 4'd4) || obs[4] !== pk(5'b0, 1, 4'd4) || obs_fl !== 2'b00) begin
      miscompares++;
      $display("FAIL mask_hold: got %b/%b flags %b want %b", obs[1], obs[4], obs_fl, pk(5'b0, 1, 4'd4));
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
    vectors++;
    if (obs[1] !== pk(5'b00101, 1, 4'd4) || obs[3][7:4] !== 4'd0) begin
      miscompares++;
      $display("FAIL mask_retry: got %b depth_c3 %0d want %b depth 0", obs[1], obs[3][7:4], pk(5'b00101, 1, 4'd4));
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 1'b0, 1'b1, 4'd7, 16'h0, 1'b0, 0);
    apply(1'b1, 1'b1, 1'b1, 4'd9, 16'h0, 1'b0, 1);
    vectors++;
    if (obs[1] !== pk(5'b10001, 2, 4'd9) || obs[4] !== pk(5'b0, 2, 4'd9) || obs_fl !== 2'b00) begin
      miscompares++;
      $display("FAIL simultaneous: got %b/%b flags %b want %b/%b flags 00",
               obs[1], obs[4], obs_fl, pk(5'b10001, 2, 4'd9), pk(5'b0, 2, 4'd9));
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 1);
    vectors++;
    if (obs[1] !== pk(5'b00101, 2, 4'd9) || obs[4] !== pk(5'b0, 1, 4'd7)) begin
      miscompares++;
      $display("FAIL busy_strobes: got %b/%b want %b/%b", obs[1], obs[4], pk(5'b00101, 2, 4'd9), pk(5'b0, 1, 4'd7));
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b0, 1'b1, 4'd6, 16'h0, 1'b0, 0);
    bus_if.pause_req = 1'b1;
    bus_if.cur_task  = 4'd8;
    step();
    bus_if.pause_req = 1'b0;
    step();
    vectors++;
    if (sample() !== pk(5'b01001, 2, 4'd8)) begin
      miscompares++;
      $display("FAIL pre_reset: got %b want %b", sample(), pk(5'b01001, 2, 4'd8));
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sample(), bus_if.overflow_err, bus_if.underflow_err} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want all zero", {sample(), bus_if.overflow_err, bus_if.underflow_err});
    end
`ifdef CRC_PAUSE_WATERMARK_EN
    vectors++;
    if (bus_if.max_depth !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset_wm: got %0d want 0", bus_if.max_depth);
    end
`endif
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    step();
    rst = 1'b0;
    step();
    apply(1'b1, 1'b0, 1'b1, 4'd2, 16'h0, 1'b0, 0);
    vectors++;
    if (obs[1] !== pk(5'b10001, 1, 4'd2)) begin
      miscompares++;
      $display("FAIL post_reset_pause: got %b want %b", obs[1], pk(5'b10001, 1, 4'd2));
    end
    apply(1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      apply(op <= 4, op >= 4, $urandom_range(0, 7) != 0, 4'($urandom), 16'($urandom & $urandom),
            $urandom_range(0, 7) == 0, 2);
      for (int c = 1; c <= 4; c++) begin
        vectors++;
        if (obs[c] !== exp_v[c]) begin
          miscompares++;
          $display("FAIL random[%0d] c%0d: got %b want %b (ps,pr,ul,us,wr,depth,rt)", i, c, obs[c], exp_v[c]);
        end
      end
      vectors++;
      if (obs_fl !== {ovf_m, unf_m}) begin
        miscompares++;
        $display("FAIL random[%0d] flags: got %b want %b", i, obs_fl, {ovf_m, unf_m});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pause();
    test_nested();
    test_overflow();
    test_mask();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/crc_pause_stack_ctrl.md
Name: crc_pause_stack_ctrl

Overview:
Pause/unpause sequencer for the fingerprint CRC unit. It supports nested pre-emption through an internal LIFO of paused task keys with parameterised depth and key width. A single unified FSM serialises pause and unpause sequences. The block adds sticky overflow/underflow error flags, a depth report and an explicit arbitration rule. It sits between the fingerprint control-register slave and the CRC datapath/context store.

Parameters:
KEY_WIDTH, 4, width of a task key; pause mask is 2**KEY_WIDTH bits
STACK_DEPTH, 8, number of nested paused contexts held (must be >= 2)
PTR_W, clog2(STACK_DEPTH)+1, width of depth counter (localparam, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pause_req  in  1  single-cycle pause strobe from register slave
unpause_req  in  1  single-cycle unpause strobe
fprint_enable  in  1  fingerprinting globally enabled
cur_task  in  KEY_WIDTH  key of task currently being fingerprinted (pushed on pause)
pause_mask  in  2**KEY_WIDTH  per-task "remain paused" bits
err_clr  in  1  clears sticky error flags
pause_store  out  1  datapath: save CRC context
pause_reset  out  1  datapath: clear CRC state
unpause_load  out  1  datapath: reload context of restore_task
unpause_setfsm  out  1  datapath: set comparator FSM; stack pops this cycle
restore_task  out  KEY_WIDTH  top-of-stack key
waitrequest  out  1  bus stall
depth  out  PTR_W  current stack occupancy
overflow_err  out  1  sticky: pause rejected, stack full
underflow_err  out  1  sticky: unpause rejected, stack empty

Behaviour:
- Reset (async, any time, including mid-sequence): FSM=IDLE, depth=0, all outputs 0, error flags 0. Stack contents are don't-care.
- States: IDLE, P_STORE, P_RESET, P_REL, U_LOAD, U_SETFSM, U_REL. All outputs are registered-state decodes: pause_store=P_STORE, pause_reset=P_RESET, unpause_load=U_LOAD, unpause_setfsm=U_SETFSM.
- waitrequest=1 in every non-IDLE state (4 cycles per sequence counting the request edge).
- Requests are sampled only in IDLE. Strobes arriving in other states are ignored (master is stalled by waitrequest).
- Pause accept: IDLE & pause_req & fprint_enable & depth<STACK_DEPTH.
  - On that edge: stack[depth]<=cur_task, depth+1, next P_STORE.
  - Sequence: P_STORE -> P_RESET -> P_REL -> IDLE, one cycle each.
- Pause with depth==STACK_DEPTH and fprint_enable=1: overflow_err<=1, stay IDLE, no push.
- Pause with fprint_enable=0: ignored silently.
- Unpause accept: IDLE & unpause_req & depth!=0 & ~pause_mask[restore_task]. Next U_LOAD.
  - Sequence: U_LOAD -> U_SETFSM -> U_REL -> IDLE.
  - depth-1 on the U_SETFSM->U_REL edge.
- Unpause with depth==0: underflow_err<=1, stay IDLE.
- Unpause with pause_mask[restore_task]=1: ignored silently.
- Simultaneous pause_req and unpause_req in IDLE: pause wins; unpause is dropped and no error is flagged.
- restore_task = stack[depth-1] when depth!=0, else 0. It is stable throughout U_LOAD and U_SETFSM.
- err_clr clears both flags; a same-cycle set wins over clear.
- Illegal/unused state encodings return to IDLE next cycle.

Optional Feature:
CRC_PAUSE_WATERMARK_EN
- Defined: adds output max_depth [PTR_W]. It is a registered high-water mark of depth, reset 0, updated on push, and cleared by err_clr (clear then reload current depth).
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
1. Reset release, pause_req at cycle 0 with fprint_enable=1, cur_task=3 -> pause_store c1, pause_reset c2, waitrequest c1-c3, depth=1, restore_task=3, IDLE at c4.
2. Three nested pauses with keys 1,2,5, then three unpauses with mask=0 -> restore_task 5,2,1 in order at U_LOAD; depth 3->0, each pop seen the cycle after unpause_setfsm.
3. STACK_DEPTH=8: nine pauses -> ninth gives overflow_err=1, depth stays 8, no pause_store. Then err_clr -> flag 0. Unpause with depth 0 -> underflow_err=1.
4. depth=1, key 4, pause_mask[4]=1, unpause_req -> no unpause_load, depth 1. Clear mask bit, retry -> normal sequence.
5. pause_req and unpause_req together in IDLE with depth=1 -> pause sequence runs, depth=2, no error. Strobes during waitrequest are ignored.
6. Assert rst during P_RESET with depth=2 -> all outputs 0 immediately, depth=0; with CRC_PAUSE_WATERMARK_EN, max_depth=0.
